// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 host transmitter and receiver.
package ps2_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK,
        S_RELEASE
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 9;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;

    // Odd parity sits above the data byte so the frame shifts out LSB first.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
        return {~^b, b};
    endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a controller and the PS/2 transmitter.
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
    modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises and deglitches ps2c, flagging filtered falling edges.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_i,
    output logic level_o,
    output logic fall_tick_o
);
    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] sh_q;
    logic                  level_q;
    logic                  level_d;

    always_comb level_d = &sh_q ? 1'b1 : ~|sh_q ? 1'b0 : level_q;

    // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            sh_q    <= '1;
            level_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], ps2c_i};
            sh_q    <= {sh_q[FILTER_LEN-2:0], sync_q[1]};
            level_q <= level_d;
        end
    end

    assign level_o     = level_q;
    assign fall_tick_o = level_q & ~level_d;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with request-to-send,
// device-clocked frame shifting, ack check and line-activity timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic           clk,
    input logic           rst,
    ps2_host_tx_if.slave  bus,
    inout wire            ps2c,
    inout wire            ps2d
);
    localparam int CNT_MAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_t                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [3:0]                bit_q, bit_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      err_q, err_d;
    logic                      done_q, done_d;
    logic [1:0]                d_sync_q;
    logic                      c_level, fall, cnt_zero, lines_high, watched;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk         (clk),
        .rst         (rst),
        .ps2c_i      (ps2c),
        .level_o     (c_level),
        .fall_tick_o (fall)
    );

    assign cnt_zero   = cnt_q == '0;
    assign lines_high = c_level & d_sync_q[1];
    assign watched    = state_q != S_IDLE && state_q != S_RTS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            d_sync_q <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            done_q   <= done_d;
            d_sync_q <= {d_sync_q[0], ps2d};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        err_d   = err_q;
        done_d  = 1'b0;
        // Once the device owns the clock, every edge restarts the watchdog.
        if (watched) cnt_d = fall ? TO_LOAD : cnt_q - 1'b1;
        case (state_q)
            S_IDLE:
                if (bus.wr_ps2) begin
                    frame_d = ps2_frame(bus.din);
                    err_d   = 1'b0;
                    cnt_d   = INH_LOAD;
                    state_d = S_RTS;
                end
            S_RTS: begin
                cnt_d = cnt_zero ? TO_LOAD : cnt_q - 1'b1;
                if (cnt_zero) state_d = S_START;
            end
            S_START:
                if (fall) begin
                    bit_d   = 4'd8;
                    state_d = S_DATA;
                end
            S_DATA:
                if (fall) begin
                    if (bit_q == 4'd0) state_d = S_STOP;
                    else begin
                        frame_d = frame_q >> 1;
                        bit_d   = bit_q - 4'd1;
                    end
                end
            S_STOP:
                if (fall) state_d = S_ACK;
            S_ACK:
                if (fall) begin
                    err_d   = d_sync_q[1];
                    state_d = S_RELEASE;
                end
            S_RELEASE:
                if (lines_high) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            default: state_d = S_IDLE;
        endcase
        if (watched && cnt_zero && !fall && !(state_q == S_RELEASE && lines_high)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
    end

    // Drives decode straight from the state register: no path from wr_ps2.
    assign ps2c = (state_q == S_RTS) ? 1'b0 : 1'bz;
    assign ps2d = (state_q == S_START || (state_q == S_DATA && !frame_q[0])) ? 1'b0 : 1'bz;

    assign bus.tx_idle      = state_q == S_IDLE;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err       = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-model bench for the PS/2 host transmitter.
module tb_ps2_host_tx;
    localparam int INH = 5000;
    localparam int FLT = 8;
    localparam int TO  = 3000;
    localparam int H   = 40;

    typedef struct {
        logic [7:0] din;
        bit         ack;
        int         glitch_k;
        int         midwr_k;
        bit         exp_par;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;
    wire  ps2c, ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .ps2c (ps2c),
        .ps2d (ps2d)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   wide_cnt = 0;
    logic prev_done = 1'b0;
    logic last_err = 1'b0;
    logic last_idle = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_done_tick) begin
            done_cnt++;
            last_err  = bus.tx_err;
            last_idle = bus.tx_idle;
        end
        if (bus.tx_done_tick && prev_done) wide_cnt++;
        prev_done = bus.tx_done_tick;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 8'd1) != 0;
            ones += int'(f[i+1]);
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic pulses(input int n, input bit ack, input int gk, input int mk,
                          inout logic [12:0] bits);
        for (int k = 1; k <= n; k++) begin
            dev_c = 1'b1;
            if (ack && k == 11) dev_d = 1'b1;
            if (k == mk) begin
                bus.wr_ps2 = 1'b1;
                bus.din    = 8'h55;
                step();
                bus.wr_ps2 = 1'b0;
                repeat (H - 1) step();
            end else repeat (H) step();
            dev_c = 1'b0;
            if (k == gk) begin
                repeat (10) step();
                dev_c = 1'b1;
                repeat (3) step();
                dev_c = 1'b0;
                repeat (H - 13) step();
            end else repeat (H) step();
            if (k <= 10) bits[k] = ps2d;
        end
        dev_d = 1'b0;
    endtask

    task automatic start_tx(input logic [7:0] d, output int lowcnt);
        bus.wr_ps2 = 1'b1;
        bus.din    = d;
        step();
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'($urandom);
        chk("idle_drop", bus.tx_idle, 0);
        chk("err_clear", bus.tx_err, 0);
        lowcnt = 0;
        while (ps2c === 1'b0 && lowcnt < INH + 100) begin
            lowcnt++;
            step();
        end
        chk("rts_len", lowcnt, INH);
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input int gk, input int mk,
                        input bit exp_par, input bit exp_err);
        logic [12:0] bits;
        logic [10:0] exp;
        int lowcnt;
        int d0;
        d0 = done_cnt;
        bits = '0;
        exp = model_frame(d);
        start_tx(d, lowcnt);
        bits[0] = ps2d;
        repeat (20) step();
        pulses(12, ack, gk, mk, bits);
        for (int i = 0; i < 200 && done_cnt == d0; i++) step();
        chk("start_bit", bits[0], 0);
        chk("data_bits", bits[8:1], exp[8:1]);
        chk("parity", bits[9], exp_par);
        chk("stop_bit", bits[10], 1);
        chk("done_count", done_cnt - d0, 1);
        chk("err_at_done", last_err, exp_err);
        chk("idle_at_done", last_idle, 1);
        chk("done_width", wide_cnt, 0);
    endtask

    initial begin
        vec_t tbl[5];
        int lowcnt, t, d0;
        logic [12:0] bits;
        logic [7:0] rd;
        bit ra;
        logic [10:0] rexp;

        tbl[0] = '{8'hED, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b1, 0, 0, 1'b1, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 0, 0, 1'b1, 1'b1};
        tbl[4] = '{8'hED, 1'b1, 4, 5, 1'b1, 1'b0};

        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        repeat (3) step();
        chk("rst_idle", bus.tx_idle, 1);
        chk("rst_done", bus.tx_done_tick, 0);
        chk("rst_err", bus.tx_err, 0);
        chk("rst_ps2c", ps2c, 1);
        chk("rst_ps2d", ps2d, 1);
        rst = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 5; i++)
            send(tbl[i].din, tbl[i].ack, tbl[i].glitch_k, tbl[i].midwr_k, tbl[i].exp_par, tbl[i].exp_err);

        for (int i = 0; i < 3; i++) begin
            rd   = 8'($urandom);
            ra   = 1'($urandom_range(0, 1));
            rexp = model_frame(rd);
            send(rd, ra, 0, 0, rexp[9], !ra);
        end

        // Device never clocks: watchdog must abort and release both lines.
        start_tx(8'hFF, lowcnt);
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < 2 * TO) begin
            step();
            t++;
        end
        chk("timeout_cycles", t, TO);
        chk("timeout_err", bus.tx_err, 1);
        chk("timeout_ps2c", ps2c, 1);
        chk("timeout_ps2d", ps2d, 1);
        chk("timeout_idle", bus.tx_idle, 1);
        repeat (5) step();
        chk("err_hold", bus.tx_err, 1);

        // Reset in the middle of the data bits, while d1=0 is being driven.
        start_tx(8'hED, lowcnt);
        repeat (20) step();
        bits = '0;
        d0 = done_cnt;
        pulses(2, 1'b0, 0, 0, bits);
        chk("pre_rst_ps2d", ps2d, 0);
        rst = 1'b1;
        #1;
        chk("midrst_ps2c", ps2c, 1);
        chk("midrst_ps2d", ps2d, 1);
        chk("midrst_idle", bus.tx_idle, 1);
        chk("midrst_err", bus.tx_err, 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("midrst_no_done", done_cnt - d0, 0);

        send(8'hFF, 1'b1, 0, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
